// File: rtl/approx_mul_pkg.sv
// Shared definitions for the approximate-multiplier accuracy checker:
// default widths, FSM encoding and a saturating adder.
package approx_mul_pkg;

  localparam int DEF_WIDTH = 16;
  localparam int DEF_ACC_W = 48;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    CMP  = 2'd2
  } state_t;

  // Adds inc to acc and clamps at the all-ones value of a w-bit register (w < 64).
  function automatic logic [63:0] sat_add(input logic [63:0] acc,
                                          input logic [63:0] inc,
                                          input int          w);
    logic [64:0] sum;
    logic [63:0] lim;
    sum = {1'b0, acc} + {1'b0, inc};
    lim = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (sum > {1'b0, lim}) ? lim : sum[63:0];
  endfunction

endpackage

// File: rtl/seq_shift_add_mul.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle, LSB first,
// WIDTH cycles after start. done is high during the final accumulation cycle.
module seq_shift_add_mul #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0]   a_r, b_r;
  logic [CW-1:0]      iter;
  logic [2*WIDTH-1:0] acc;

  assign done    = busy && (iter == CW'(WIDTH - 1));
  assign product = acc;

  // Partial sums never exceed the final product, so 2*WIDTH bits cannot overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      iter <= '0;
      acc  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      a_r  <= a;
      b_r  <= b;
      iter <= '0;
      acc  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      if (b_r[iter])
        acc <= acc + ({{WIDTH{1'b0}}, a_r} << iter);
      iter <= iter + 1'b1;
      if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/approx_mul_error_checker.sv
// Compares two approximate products against an exactly computed a*b and keeps
// saturating running error statistics.
module approx_mul_error_checker
  import approx_mul_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ACC_W = DEF_ACC_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic [2*WIDTH-1:0]   res1,
  input  logic [2*WIDTH-1:0]   res2,
  input  logic                 stats_clear,
  output logic                 out_valid,
  output logic [2*WIDTH-1:0]   exact,
  output logic [2*WIDTH-1:0]   err1,
  output logic [2*WIDTH-1:0]   err2,
  output logic [ACC_W-1:0]     sum_err1,
  output logic [ACC_W-1:0]     sum_err2,
  output logic [2*WIDTH-1:0]   max_err1,
  output logic [2*WIDTH-1:0]   max_err2,
  output logic [CNT_W-1:0]     match1,
  output logic [CNT_W-1:0]     match2,
  output logic [CNT_W-1:0]     samples
);

  localparam int PW = 2 * WIDTH;

  state_t          state, state_nx;
  logic            accept;
  logic            mul_busy, mul_done;
  logic [PW-1:0]   product;
  logic [PW-1:0]   res1_r, res2_r;
  logic [PW-1:0]   e1, e2;

  logic [ACC_W-1:0] sum1_base, sum2_base;
  logic [PW-1:0]    max1_base, max2_base;
  logic [CNT_W-1:0] m1_base, m2_base, smp_base;

  function automatic logic [PW-1:0] abs_diff(input logic [PW-1:0] x, input logic [PW-1:0] y);
    logic [PW:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[PW])
      d = {1'b0, y} - {1'b0, x};
    return d[PW-1:0];
  endfunction

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;

  seq_shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .a       (a),
    .b       (b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (product)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = MUL;
      MUL:     if (mul_done) state_nx = CMP;
      CMP:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign e1 = abs_diff(product, res1_r);
  assign e2 = abs_diff(product, res2_r);

  // A clear coinciding with CMP restarts the statistics from this sample.
  assign sum1_base = stats_clear ? '0 : sum_err1;
  assign sum2_base = stats_clear ? '0 : sum_err2;
  assign max1_base = stats_clear ? '0 : max_err1;
  assign max2_base = stats_clear ? '0 : max_err2;
  assign m1_base   = stats_clear ? '0 : match1;
  assign m2_base   = stats_clear ? '0 : match2;
  assign smp_base  = stats_clear ? '0 : samples;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      res1_r    <= '0;
      res2_r    <= '0;
      exact     <= '0;
      err1      <= '0;
      err2      <= '0;
      sum_err1  <= '0;
      sum_err2  <= '0;
      max_err1  <= '0;
      max_err2  <= '0;
      match1    <= '0;
      match2    <= '0;
      samples   <= '0;
    end else begin
      out_valid <= (state == CMP);
      if (accept) begin
        res1_r <= res1;
        res2_r <= res2;
      end
      if (state == CMP) begin
        exact    <= product;
        err1     <= e1;
        err2     <= e2;
        sum_err1 <= ACC_W'(sat_add(64'(sum1_base), 64'(e1), ACC_W));
        sum_err2 <= ACC_W'(sat_add(64'(sum2_base), 64'(e2), ACC_W));
        max_err1 <= (e1 > max1_base) ? e1 : max1_base;
        max_err2 <= (e2 > max2_base) ? e2 : max2_base;
        match1   <= (e1 == '0) ? CNT_W'(sat_add(64'(m1_base), 64'd1, CNT_W)) : m1_base;
        match2   <= (e2 == '0) ? CNT_W'(sat_add(64'(m2_base), 64'd1, CNT_W)) : m2_base;
        samples  <= CNT_W'(sat_add(64'(smp_base), 64'd1, CNT_W));
      end else if (stats_clear) begin
        sum_err1 <= '0;
        sum_err2 <= '0;
        max_err1 <= '0;
        max_err2 <= '0;
        match1   <= '0;
        match2   <= '0;
        samples  <= '0;
      end
    end
  end

endmodule
